// File: rtl/slice_ctrl_pkg.sv
// Shared sizing, state encoding and helpers for the slice_ctrl window sequencer.
// Window depth and sample width are fixed here for every user of the slice.
package slice_ctrl_pkg;

  localparam int dwidth_dat   = 8;
  localparam int dwidth_slice = 3;
  localparam int win_w        = dwidth_dat * dwidth_slice;

  // Accept counter saturates at dwidth_slice+1; window fill count tops out at dwidth_slice.
  localparam int n_w   = $clog2(dwidth_slice + 2);
  localparam int cnt_w = $clog2(dwidth_slice + 1);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  function automatic logic [cnt_w-1:0] sat_cnt(input logic [n_w-1:0] v);
    if (v >= n_w'(dwidth_slice)) return cnt_w'(dwidth_slice);
    else return cnt_w'(v);
  endfunction

endpackage

// File: rtl/slice_ctrl_slice.sv
// buffer_slice: hidden stage-0 register feeding a dwidth_slice-deep window shift register.
// wen loads stage 0, pop shifts stage 0 into the window; rst clears both synchronously.
module buffer_slice
  import slice_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic                  pop,
  input  logic [dwidth_dat-1:0] wdata,
  output logic [win_w-1:0]      rdata
);

  logic [dwidth_dat-1:0] stage0;
  logic [win_w-1:0]      win;

  // Newest sample lands in the low lane, oldest falls off the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage0 <= '0;
      win    <= '0;
    end else begin
      if (wen) stage0 <= wdata;
      if (pop) win <= {win[win_w-dwidth_dat-1:0], stage0};
    end
  end

  assign rdata = win;

endmodule

// File: rtl/slice_ctrl.sv
// slice_ctrl: streams samples into a buffer_slice and emits each full window on a valid/ready port.
// Optional build macro SLICE_CTRL_STRIDE_EN: emit only every STRIDE-th full window of a row.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_CLEAR  | zero the slice and the row counters, then start a new row
// ST_ACTIVE | accept samples; each accept shifts the slice by one
// ST_FLUSH  | push the hidden stage-0 sample into the window (row's last)
module slice_ctrl
  import slice_ctrl_pkg::*;
#(
  parameter int STRIDE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [dwidth_dat-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [win_w-1:0]      m_data,
  output logic                  m_last
);

  localparam logic [n_w-1:0]   n_max    = n_w'(dwidth_slice + 1);
  localparam logic [cnt_w-1:0] cnt_full = cnt_w'(dwidth_slice);

  state_t           state, state_nxt;
  logic [n_w-1:0]   n_q, n_nxt;
  logic [cnt_w-1:0] cnt_q, cnt_nxt;
  logic             free;
  logic             clr, acc_pop, flush_pop;
  logic             sl_rst, sl_wen, sl_pop;
  logic             stride_hit, emit;
  logic             m_valid_nxt, m_last_nxt;

  // Nothing moves in the slice while an unaccepted window is on the output.
  assign free = !m_valid || m_ready;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    sl_rst    = 1'b0;
    sl_wen    = 1'b0;
    sl_pop    = 1'b0;
    clr       = 1'b0;
    acc_pop   = 1'b0;
    flush_pop = 1'b0;
    case (state)
      ST_CLEAR: begin
        if (free) begin
          sl_rst    = 1'b1;
          sl_wen    = 1'b1;
          sl_pop    = 1'b1;
          clr       = 1'b1;
          state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        s_ready = free;
        if (s_valid && free) begin
          sl_wen  = 1'b1;
          sl_pop  = 1'b1;
          acc_pop = 1'b1;
          if (s_last) state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (free) begin
          sl_pop    = 1'b1;
          flush_pop = 1'b1;
          state_nxt = ST_CLEAR;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // An accept pop exposes samples n-1..n-N; the flush pop exposes n..n-N+1.
  always_comb begin
    n_nxt   = n_q;
    cnt_nxt = cnt_q;
    if (clr) begin
      n_nxt   = '0;
      cnt_nxt = '0;
    end else if (acc_pop) begin
      n_nxt   = (n_q == n_max) ? n_q : n_q + n_w'(1);
      cnt_nxt = sat_cnt(n_nxt - n_w'(1));
    end else if (flush_pop) begin
      cnt_nxt = sat_cnt(n_q);
    end
  end

`ifdef SLICE_CTRL_STRIDE_EN
  localparam int sw = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  logic [sw-1:0] sidx_q;

  assign stride_hit = (sidx_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sidx_q <= '0;
    end else if (clr) begin
      sidx_q <= '0;
    end else if (acc_pop && cnt_nxt == cnt_full) begin
      sidx_q <= (sidx_q == sw'(STRIDE - 1)) ? '0 : sidx_q + sw'(1);
    end
  end
`else
  assign stride_hit = 1'b1;
`endif

  // The flush window bypasses the stride filter so every row reports its last window.
  always_comb begin
    emit        = (acc_pop && cnt_nxt == cnt_full && stride_hit) ||
                  (flush_pop && cnt_nxt == cnt_full);
    m_valid_nxt = m_valid;
    m_last_nxt  = m_last;
    if (emit) begin
      m_valid_nxt = 1'b1;
      m_last_nxt  = flush_pop;
    end else if (m_ready) begin
      m_valid_nxt = 1'b0;
      m_last_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      n_q     <= '0;
      cnt_q   <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      state   <= state_nxt;
      n_q     <= n_nxt;
      cnt_q   <= cnt_nxt;
      m_valid <= m_valid_nxt;
      m_last  <= m_last_nxt;
    end
  end

  buffer_slice u_slice (
    .clk   (clk),
    .rst   (sl_rst),
    .wen   (sl_wen),
    .pop   (sl_pop),
    .wdata (s_data),
    .rdata (m_data)
  );

endmodule
